// File: rtl/mure_pkg.sv
// Shared types and constants for the multiple-retirement block decoder.
// Provides:
//   - field widths of the block interface (XLEN, IRETIRE_LEN, ...)
//   - itype constants 0..6
//   - raw_block_s : the block record as captured from the front end
//   - dec_block_s : the decoded record presented to the consumer
//   - dec_state_e : continuity checker state
package mure_pkg;

    localparam int XLEN        = 32;
    localparam int IRETIRE_LEN = 8;
    localparam int ITYPE_LEN   = 3;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;

    localparam logic [ITYPE_LEN-1:0] ITYPE_NONE = 3'd0;
    localparam logic [ITYPE_LEN-1:0] ITYPE_EXC  = 3'd1;
    localparam logic [ITYPE_LEN-1:0] ITYPE_INT  = 3'd2;
    localparam logic [ITYPE_LEN-1:0] ITYPE_ERET = 3'd3;
    localparam logic [ITYPE_LEN-1:0] ITYPE_NTB  = 3'd4;
    localparam logic [ITYPE_LEN-1:0] ITYPE_TB   = 3'd5;
    localparam logic [ITYPE_LEN-1:0] ITYPE_UIJ  = 3'd6;

    // Bit positions inside dec_block_s.flags
    localparam int FLAG_MAL  = 1;
    localparam int FLAG_DISC = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        FREE = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [XLEN-1:0]        tval;
        logic [CAUSE_LEN-1:0]   cause;
        logic [PRIV_LEN-1:0]    priv;
        logic [ITYPE_LEN-1:0]   itype;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
    } raw_block_s;

    typedef struct packed {
        logic [XLEN-1:0]        start;
        logic [XLEN-1:0]        last;
        logic [XLEN-1:0]        next;
        logic [IRETIRE_LEN-1:0] hw_cnt;
        logic [ITYPE_LEN-1:0]   itype;
        logic [PRIV_LEN-1:0]    priv;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [1:0]             flags;   // {malformed, discont}
    } dec_block_s;

    // Blocks ending in these types leave the following block at a known
    // address, so the next block can be checked for continuity.
    function automatic logic is_sequential(input logic [ITYPE_LEN-1:0] itype);
        return (itype == ITYPE_NONE) || (itype == ITYPE_NTB);
    endfunction

    // An empty block is only legal when it reports a trap.
    function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
        return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
    endfunction

endpackage

// File: rtl/mure_block_fifo.sv
// Record buffer for the block decoder.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, wdata  write one record (caller guarantees !full || pop)
//   pop          remove the head record (caller guarantees !empty)
//   rdata        current head record (valid while !empty)
//   full, empty  occupancy status
// Push and pop in the same cycle are allowed at any occupancy, including full.
module mure_block_fifo
    import mure_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  raw_block_s wdata,
    input  logic       pop,
    output raw_block_s rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    raw_block_s     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mure_block_decoder.sv
// Receiving end of the multiple-retirement block interface.
// Buffers incoming block records, decodes the retired PC range of the head
// record, checks continuity between consecutive popped blocks, and keeps
// sticky error flags plus saturating block/halfword counters.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   valid_i + block fields incoming record (no backpressure upstream)
//   clear_i                zero sticky flags and counters
//   valid_o, ready_i, blk_o decoded head record and its handshake
//   overflow_o, malformed_o, discont_o  sticky flags
//   blk_cnt_o, hw_cnt_o    saturating statistics
//   state_o                continuity checker state (debug)
// Handshake: blk_o is transferred on a cycle where valid_o && ready_i;
// while valid_o is high and ready_i low, blk_o holds its value.
module mure_block_decoder
    import mure_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic [IRETIRE_LEN-1:0] iretire_i,
    input  logic                   ilastsize_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [CAUSE_LEN-1:0]   cause_i,
    input  logic [XLEN-1:0]        tval_i,
    input  logic [PRIV_LEN-1:0]    priv_i,
    input  logic [XLEN-1:0]        iaddr_i,
    input  logic                   clear_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output dec_block_s             blk_o,
    output logic                   overflow_o,
    output logic                   malformed_o,
    output logic                   discont_o,
    output logic [CNT_W-1:0]       blk_cnt_o,
    output logic [CNT_W-1:0]       hw_cnt_o,
    output dec_state_e             state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    raw_block_s       wdata;
    raw_block_s       head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;

    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  last_pc;
    logic             malformed;
    logic             discont;

    dec_state_e       state_q, state_d;
    logic [XLEN-1:0]  exp_q, exp_d;
    logic             ovf_q, ovf_d;
    logic             mal_q, mal_d;
    logic             disc_q, disc_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0] hw_cnt_q, hw_cnt_d;
    logic [CNT_W:0]   blk_sum;
    logic [CNT_W:0]   hw_sum;

    assign wdata = '{iaddr: iaddr_i, tval: tval_i, cause: cause_i, priv: priv_i,
                     itype: itype_i, iretire: iretire_i, ilastsize: ilastsize_i};

    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    // A slot freed by a same-cycle pop can take the new record.
    assign push    = valid_i && (!full || pop);
    assign drop    = valid_i && full && !pop;

    mure_block_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Head decode and continuity check.
    always_comb begin
        next_pc   = head.iaddr + (XLEN'(head.iretire) << 1);
        last_pc   = next_pc - (head.ilastsize ? XLEN'(4) : XLEN'(2));
        malformed = ((head.iretire == '0) && !is_trap(head.itype)) ||
                    ((head.iretire == IRETIRE_LEN'(1)) && head.ilastsize);
        // Empty or malformed blocks collapse to a single point at start.
        if (malformed || (head.iretire == '0)) begin
            last_pc = head.iaddr;
            next_pc = head.iaddr;
        end
        discont = !malformed && (state_q == SEQ) && (head.iaddr != exp_q);
    end

    always_comb begin
        blk_o = '0;
        if (!empty) begin
            blk_o.start  = head.iaddr;
            blk_o.last   = last_pc;
            blk_o.next   = next_pc;
            blk_o.hw_cnt = head.iretire;
            blk_o.itype  = head.itype;
            blk_o.priv   = head.priv;
            blk_o.cause  = head.cause;
            blk_o.tval   = head.tval;
            blk_o.flags  = {malformed, discont};
        end
    end

    // Continuity FSM: all states leave the same way, only SEQ checks.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        if (pop) begin
            if (malformed) begin
                state_d = IDLE;
            end else begin
                state_d = is_sequential(head.itype) ? SEQ : FREE;
                exp_d   = next_pc;
            end
        end
    end

    // Sticky flags and counters; clear_i drops the old value but keeps
    // whatever happens in the clearing cycle itself.
    always_comb begin
        ovf_d     = (clear_i ? 1'b0 : ovf_q)  | drop;
        mal_d     = (clear_i ? 1'b0 : mal_q)  | (pop && malformed);
        disc_d    = (clear_i ? 1'b0 : disc_q) | (pop && discont);
        blk_sum   = {1'b0, (clear_i ? '0 : blk_cnt_q)} + (CNT_W+1)'(pop);
        hw_sum    = {1'b0, (clear_i ? '0 : hw_cnt_q)} +
                    (pop ? (CNT_W+1)'(head.iretire) : '0);
        blk_cnt_d = blk_sum[CNT_W] ? CNT_MAX : blk_sum[CNT_W-1:0];
        hw_cnt_d  = hw_sum[CNT_W]  ? CNT_MAX : hw_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            ovf_q     <= 1'b0;
            mal_q     <= 1'b0;
            disc_q    <= 1'b0;
            blk_cnt_q <= '0;
            hw_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            ovf_q     <= ovf_d;
            mal_q     <= mal_d;
            disc_q    <= disc_d;
            blk_cnt_q <= blk_cnt_d;
            hw_cnt_q  <= hw_cnt_d;
        end
    end

    assign overflow_o  = ovf_q;
    assign malformed_o = mal_q;
    assign discont_o   = disc_q;
    assign blk_cnt_o   = blk_cnt_q;
    assign hw_cnt_o    = hw_cnt_q;
    assign state_o     = state_q;

endmodule

// File: doc/mure_block_decoder.md
# mure_block_decoder

Receiving end of the multiple-retirement block interface. It accepts the instruction-block records that the multiple-retirement front end emits towards the trace encoder, and buffers them. For each block it reconstructs the retired address range (first, last and next-sequential PC). It also checks continuity between consecutive blocks and flags malformed or discontinuous blocks, for use as an on-chip monitor and as a scoreboard front end in the encoder bench.

## Interface
- DEPTH, 4: buffer entries, power of two, at least 2.
- CNT_W, 32: width of the block and halfword statistics counters.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, synchronous, active-low.
- valid_i  in  1  block present; no backpressure is possible upstream.
- iretire_i  in  mure_pkg::IRETIRE_LEN  halfwords retired in the block.
- ilastsize_i  in  1  size of the last instruction: 0 = 16-bit, 1 = 32-bit.
- itype_i  in  mure_pkg::ITYPE_LEN  type of the last instruction.
- cause_i, tval_i, priv_i  in  CAUSE_LEN/XLEN/PRIV_LEN  trap info; passed through.
- iaddr_i  in  mure_pkg::XLEN  address of the first instruction in the block.
- clear_i  in  1  clears the sticky flags and the counters.
- valid_o  out  1  decoded record available.
- ready_i  in  1  consumer accepts the record.
- blk_o  out  mure_pkg::dec_block_s  record fields: start, last, next, hw_cnt, itype, priv, cause, tval, flags.
- overflow_o  out  1  sticky; a block was dropped.
- malformed_o  out  1  sticky; a malformed block was popped.
- discont_o  out  1  sticky; a continuity violation was popped.
- blk_cnt_o, hw_cnt_o  out  CNT_W  blocks popped and halfwords popped; both saturate.

## Operation
- Push: valid_i pushes the raw record if the buffer is not full.
  - valid_i while full drops the block and sets overflow_o.
- Pop: occurs on valid_o && ready_i. The record is decoded combinationally from the buffer head.
  - start = iaddr.
  - next = iaddr + (iretire << 1), modulo 2^XLEN.
  - last = next − (ilastsize ? 4 : 2), modulo 2^XLEN.
  - hw_cnt = iretire.
- Malformed: iretire == 0 with itype not in {1 exception, 2 interrupt}; or iretire == 1 with ilastsize == 1.
  - For a malformed block, last is forced to start and next to start.
  - For iretire == 0 with itype 1 or 2: last = next = start; this is not malformed.
- Continuity FSM, evaluated on each pop:
  - IDLE: no reference. Go to SEQ if the popped itype is in {0 none, 4 not-taken branch}, else go to FREE.
  - SEQ: expect start == exp_q. A mismatch flags discont. Then transition exactly as from IDLE.
  - FREE: covers itype 1, 2, 3, 5, 6; the target is unknown, so nothing is checked. Then transition exactly as from IDLE.
- exp_q is loaded with next on every non-malformed pop. A malformed pop sends the FSM to IDLE without checking continuity.
- Flags in blk_o: {malformed, discont} for that record. The sticky outputs set on the popping cycle.
- Counters update on pop: blk_cnt += 1, hw_cnt += iretire. Both saturate at all-ones.
- clear_i: zeros the sticky flags and counters on the next edge.
  - It does not flush the buffer or the FSM.
  - Events in the same cycle as clear_i win: a flag set in that cycle stays set, and the counter holds that cycle's increment only.

## Timing
- Latency: valid_i in cycle N gives valid_o in cycle N+1 at the earliest. The buffer is registered and the head decode is combinational.
- Simultaneous push and pop while full is permitted; no drop occurs.
- Throughput is one block per cycle with ready_i held high.
- valid_o stays high and blk_o stays stable until accepted.
- Reset (also when asserted mid-stream): buffer empty, FSM in IDLE, exp_q = 0, all outputs 0, blk_o = '0. Blocks in flight are lost without setting overflow.

## Structure
- mure_pkg adds: dec_block_s, the itype constants (0..6), and the dec_state_e enum {IDLE, SEQ, FREE}.
- Sub-module mure_block_fifo: synchronous active-low reset, DEPTH entries, full/empty, push/pop in the same cycle allowed when full.
- The top level contains the decode arithmetic, the FSM, the sticky flags and the counters.

## Test plan
- Sequential blocks, all itype 0:
  - Input: iaddr 0x1000 iretire 4 ilastsize 1, then iaddr 0x1008 iretire 3 ilastsize 0.
  - Expected: last 0x1004/0x100C, next 0x1008/0x100E, discont 0, hw_cnt_o 7.
- Discontinuity:
  - Input: itype 4 block with next 0x2010, followed by a block with iaddr 0x2014.
  - Expected: discont set in blk_o and discont_o = 1. After a taken branch (itype 5), the same address jump gives no flag.
- Malformed:
  - Case 1: iretire 1 with ilastsize 1 → malformed_o = 1, last = next = start, FSM IDLE; the next block is not checked.
  - Case 2: iretire 0 with itype 1 → not malformed.
- Overflow:
  - Input: ready_i = 0, 5 consecutive valid_i with DEPTH 4.
  - Expected: overflow_o = 1, exactly 4 records drain in order.
  - Push and pop at full with ready_i = 1 → no overflow.
- Wrap and saturation:
  - Input: iaddr 0xFFFF_FFFC iretire 4 (XLEN 32).
  - Expected: next 0x0000_0004.
  - Counter preloaded near all-ones saturates rather than wrapping; clear_i zeroes it.
- Mid-stream reset:
  - Input: rst_ni low for one cycle with 3 entries buffered and FSM in SEQ.
  - Expected: valid_o = 0 next cycle, flags and counters 0, the first block after reset is not checked for continuity.
